// File: rtl/gf_pkg.sv
// Shared types and constants for the iterative GF(2^n) multiplier.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } gf_state_e;

  localparam logic [7:0] GF_AES_POLY = 8'h1B;

endpackage

// File: rtl/gf_mac_step.sv
// One shift-and-add step: conditional accumulate, then multiply the multiplicand by x.
module gf_mac_step #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 8'h1B
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o
);

  assign acc_o = bit_i ? (acc_i ^ mcand_i) : acc_i;

  // The shifted-out x^WIDTH term folds back in as the low part of the polynomial.
  assign mcand_o = {mcand_i[WIDTH-2:0], 1'b0} ^ (mcand_i[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/gf_mult_iter.sv
// Iterative GF(2^WIDTH) multiplier, LSB-first, BITS_PER_CYCLE multiplier bits per clock,
// with a fixed data-independent latency and valid/ready handshakes on both sides.
module gf_mult_iter
  import gf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(GF_AES_POLY),
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] product_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("gf_mult_iter: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  gf_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mlier_q, mlier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_chain   [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] mcand_chain [BITS_PER_CYCLE+1];

  assign acc_chain[0]   = acc_q;
  assign mcand_chain[0] = mcand_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    gf_mac_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .acc_i   (acc_chain[i]),
      .mcand_i (mcand_chain[i]),
      .bit_i   (mlier_q[i]),
      .acc_o   (acc_chain[i+1]),
      .mcand_o (mcand_chain[i+1])
    );
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign product_o   = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mlier_d = mlier_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = BUSY;
          acc_d   = '0;
          mcand_d = a_i;
          mlier_d = b_i;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d   = acc_chain[BITS_PER_CYCLE];
        mcand_d = mcand_chain[BITS_PER_CYCLE];
        mlier_d = mlier_q >> BITS_PER_CYCLE;
        cnt_d   = cnt_q + CNT_W'(1);
        // No early exit: the step count is fixed regardless of operand values.
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mlier_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mlier_q <= mlier_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gf_mult_iter.sv
// Testbench for gf_mult_iter: directed AES-field checks with handshake and reset cases,
// random checks over all BITS_PER_CYCLE settings, and a 4-bit field instance.
module tb_gf_mult_iter;

  int compared   = 0;
  int mismatched = 0;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst_np = 1'b1;

  always #5 clk = ~clk;

  // Carry-less product followed by long division by the full polynomial.
  function automatic logic [31:0] gf_ref(input logic [31:0] a, input logic [31:0] b,
                                         input int w, input logic [31:0] poly);
    logic [63:0] p;
    logic [63:0] full;
    p = '0;
    for (int i = 0; i < w; i++) begin
      if (b[i]) p = p ^ (64'(a) << i);
    end
    full = (64'd1 << w) | 64'(poly);
    for (int i = 2 * w - 2; i >= w; i--) begin
      if (p[i]) p = p ^ (full << (i - w));
    end
    return p[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- main DUT: default parameters ----------------
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] a_in      = '0;
  logic [7:0] b_in      = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] product;
  logic [7:0] sb_q[$];
  logic [7:0] last_exp;

  gf_mult_iter u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product)
  );

  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a_in     = op_a;
    b_in     = op_b;
    in_valid = 1'b1;
    sb_q.push_back(8'(gf_ref(32'(op_a), 32'(op_b), 8, 32'h1B)));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("accept_ready_low", 32'(in_ready), 32'd0);
  endtask

  task automatic waitResult(input string tag, input int exp_lat);
    int lat = 0;
    int ready_busy = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_busy++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_ready_while_busy"}, 32'(ready_busy), 32'd0);
    last_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    checkOutput({tag, "_product"}, 32'(product), 32'(last_exp));
  endtask

  task automatic doHandshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- random instances over BITS_PER_CYCLE ----------------
  for (genvar g = 0; g < 4; g++) begin : g_bpc
    localparam int BPC = 1 << g;
    localparam int N   = 8 / BPC;
    logic       iv   = 1'b0;
    logic       ir;
    logic       ov;
    logic       ordy = 1'b0;
    logic [7:0] pa   = '0;
    logic [7:0] pb   = '0;
    logic [7:0] pp;
    logic [7:0] sb[$];
    logic       done = 1'b0;

    gf_mult_iter #(
      .WIDTH          (8),
      .POLY           (8'h1B),
      .BITS_PER_CYCLE (BPC)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_np),
      .in_valid_i  (iv),
      .in_ready_o  (ir),
      .a_i         (pa),
      .b_i         (pb),
      .out_valid_o (ov),
      .out_ready_i (ordy),
      .product_o   (pp)
    );

    initial begin
      int lat;
      repeat (6) @(posedge clk);
      #1;
      for (int k = 0; k < 1000; k++) begin
        pa = 8'($urandom);
        pb = 8'($urandom);
        if (k == 0) begin pa = 8'h00; pb = 8'hFF; end
        if (k == 1) begin pa = 8'hFF; pb = 8'hFF; end
        if (k == 2) begin pa = 8'h57; pb = 8'h13; end
        iv = 1'b1;
        sb.push_back(8'(gf_ref(32'(pa), 32'(pb), 8, 32'h1B)));
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        checkOutput($sformatf("bpc%0d_latency", BPC), 32'(lat), 32'(N));
        checkOutput($sformatf("bpc%0d_product_%0d", BPC, k), 32'(pp),
                    32'((sb.size() > 0) ? sb.pop_front() : 8'h00));
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  // ---------------- 4-bit field instance ----------------
  logic       w4_iv   = 1'b0;
  logic       w4_ir;
  logic       w4_ov;
  logic       w4_ordy = 1'b0;
  logic [3:0] w4_a    = '0;
  logic [3:0] w4_b    = '0;
  logic [3:0] w4_p;
  logic [3:0] w4_sb[$];
  logic       w4_done = 1'b0;

  gf_mult_iter #(
    .WIDTH          (4),
    .POLY           (4'h3),
    .BITS_PER_CYCLE (1)
  ) u_dut_w4 (
    .clk_i       (clk),
    .rst_ni      (rst_np),
    .in_valid_i  (w4_iv),
    .in_ready_o  (w4_ir),
    .a_i         (w4_a),
    .b_i         (w4_b),
    .out_valid_o (w4_ov),
    .out_ready_i (w4_ordy),
    .product_o   (w4_p)
  );

  initial begin
    logic [3:0] ops_a [2];
    logic [3:0] ops_b [2];
    logic [3:0] ops_e [2];
    int lat;
    ops_a[0] = 4'h7; ops_b[0] = 4'h7; ops_e[0] = 4'h6;
    ops_a[1] = 4'h2; ops_b[1] = 4'h8; ops_e[1] = 4'h3;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      w4_a  = ops_a[k];
      w4_b  = ops_b[k];
      w4_iv = 1'b1;
      w4_sb.push_back(ops_e[k]);
      checkOutput($sformatf("w4_model_%0d", k),
                  gf_ref(32'(ops_a[k]), 32'(ops_b[k]), 4, 32'h3), 32'(ops_e[k]));
      @(posedge clk); #1;
      w4_iv = 1'b0;
      lat = 0;
      while (!w4_ov && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput($sformatf("w4_latency_%0d", k), 32'(lat), 32'd4);
      checkOutput($sformatf("w4_product_%0d", k), 32'(w4_p),
                  32'((w4_sb.size() > 0) ? w4_sb.pop_front() : 4'h0));
      w4_ordy = 1'b1;
      @(posedge clk); #1;
      w4_ordy = 1'b0;
    end
    w4_done = 1'b1;
  end

  // ---------------- directed sequence and summary ----------------
  initial begin
    int seen;
    int guard;
    logic all_done;

    #2;
    rst_n  = 1'b0;
    rst_np = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst_np = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h57, 8'h13);
    waitResult("p57x13", 8);
    checkOutput("p57x13_const", 32'(product), 32'hFE);
    doHandshake("p57x13");

    applyStimulus(8'h57, 8'h83);
    waitResult("p57x83", 8);
    checkOutput("p57x83_const", 32'(product), 32'hC1);
    doHandshake("p57x83");

    applyStimulus(8'h13, 8'h13);
    waitResult("p13x13", 8);
    checkOutput("p13x13_const", 32'(product), 32'h1E);
    doHandshake("p13x13");

    applyStimulus(8'h00, 8'hFF);
    waitResult("p00xFF", 8);
    checkOutput("p00xFF_const", 32'(product), 32'h00);
    doHandshake("p00xFF");

    // Back-pressure: result held while new operands are offered and must be ignored.
    applyStimulus(8'h57, 8'h83);
    waitResult("bp", 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_product_%0d", i), 32'(product), 32'(last_exp));
      checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    doHandshake("bp");
    applyStimulus(8'h13, 8'h13);
    waitResult("after_bp", 8);
    doHandshake("after_bp");

    // out_ready held high ahead of completion.
    out_ready = 1'b1;
    applyStimulus(8'hCA, 8'h53);
    waitResult("early_ready", 8);
    checkOutput("early_ready_const", 32'(product), 32'h01);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("early_ready_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("early_ready_in_ready", 32'(in_ready), 32'd1);

    // Reset during the third busy cycle discards the in-flight result.
    applyStimulus(8'h57, 8'h13);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_product", 32'(product), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_valid", 32'(seen), 32'd0);
    applyStimulus(8'h57, 8'h13);
    waitResult("post_rst", 8);
    checkOutput("post_rst_const", 32'(product), 32'hFE);
    doHandshake("post_rst");

    guard = 0;
    all_done = 1'b0;
    while (!all_done && guard < 40000) begin
      @(posedge clk);
      guard++;
      all_done = g_bpc[0].done & g_bpc[1].done & g_bpc[2].done & g_bpc[3].done & w4_done;
    end
    checkOutput("param_runs_done", 32'(all_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
